// File: rtl/intensity_pwm_pkg.sv
// Shared types and constants for the haptic intensity PWM block.
package intensity_pwm_pkg;

    localparam int unsigned INTENSITY_W   = 4;
    localparam int unsigned INTENSITY_MAX = 8;
    localparam int unsigned NUM_SLOTS     = 8;
    localparam int unsigned SLOT_W        = 3;

    typedef logic [INTENSITY_W-1:0] intensity_t;
    typedef logic [SLOT_W-1:0]      slot_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        KICK = 2'd2
    } state_e;

    // Out-of-range codes saturate at the strongest level.
    function automatic intensity_t clamp_intensity(input intensity_t raw);
        return (raw > INTENSITY_W'(INTENSITY_MAX)) ? INTENSITY_W'(INTENSITY_MAX) : raw;
    endfunction

endpackage : intensity_pwm_pkg

// File: rtl/intensity_pwm_frame_timer.sv
// Step/slot counters for one PWM frame; emits frame-start and last-cycle strobes.
module pwm_frame_timer
    import intensity_pwm_pkg::*;
#(
    parameter int unsigned STEP = 500
) (
    input  logic  clk_i,
    input  logic  reset_i,
    output logic  frame_start_o,
    output logic  frame_last_o,
    output slot_t slot_nxt_c_o
);

    localparam int unsigned STEP_W    = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP - 1);
    localparam slot_t             SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);

    logic              started_q, started_d;
    logic [STEP_W-1:0] step_q, step_d;
    slot_t             slot_q, slot_d;
    logic              frame_start_q, frame_start_d;
    logic              last_q, last_d;

    // The first post-reset cycle is cycle 0 of frame 0, so counting is held off for one edge.
    always_comb begin
        started_d     = 1'b1;
        step_d        = step_q;
        slot_d        = slot_q;
        frame_start_d = 1'b0;
        if (!started_q) begin
            step_d        = '0;
            slot_d        = '0;
            frame_start_d = 1'b1;
        end else if (step_q == STEP_LAST) begin
            step_d = '0;
            if (slot_q == SLOT_LAST) begin
                slot_d        = '0;
                frame_start_d = 1'b1;
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end else begin
            step_d = step_q + STEP_W'(1);
        end
        last_d = (slot_d == SLOT_LAST) && (step_d == STEP_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            started_q     <= 1'b0;
            step_q        <= '0;
            slot_q        <= '0;
            frame_start_q <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            started_q     <= started_d;
            step_q        <= step_d;
            slot_q        <= slot_d;
            frame_start_q <= frame_start_d;
            last_q        <= last_d;
        end
    end

    assign frame_start_o = frame_start_q;
    assign frame_last_o  = last_q;
    assign slot_nxt_c_o  = slot_d;

endmodule : pwm_frame_timer

// File: rtl/intensity_pwm.sv
// Slew-limited 8-slot PWM drive for the haptic motor from a 0..8 intensity code.
// Optional start-from-rest kick enabled by defining INTENSITY_PWM_KICKSTART_EN.
module intensity_pwm
    import intensity_pwm_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = 4000,
    parameter int unsigned KICK_FRAMES  = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  intensity_t intensity_i,
    output logic       pwm_o,
    output intensity_t level_o,
    output logic       frame_start_o
);

    localparam int unsigned STEP = FRAME_CYCLES / NUM_SLOTS;

    if (((FRAME_CYCLES % NUM_SLOTS) != 0) || (FRAME_CYCLES < 16) || (KICK_FRAMES < 1))
    begin : g_param_check
        $error("intensity_pwm: FRAME_CYCLES must be a multiple of 8 and >= 16, KICK_FRAMES >= 1");
    end

    logic       frame_last;
    slot_t      slot_nxt;
    intensity_t target_c;
    intensity_t slew_c;

    state_e     state_q, state_d;
    intensity_t level_q, level_d;
    logic       pwm_q, pwm_d;

    pwm_frame_timer #(
        .STEP (STEP)
    ) u_timer (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .frame_start_o(frame_start_o),
        .frame_last_o (frame_last),
        .slot_nxt_c_o (slot_nxt)
    );

    assign target_c = clamp_intensity(intensity_i);

    // One step per frame toward the sampled target.
    always_comb begin
        slew_c = level_q;
        if (level_q < target_c) begin
            slew_c = level_q + INTENSITY_W'(1);
        end else if (level_q > target_c) begin
            slew_c = level_q - INTENSITY_W'(1);
        end
    end

`ifdef INTENSITY_PWM_KICKSTART_EN
    localparam int unsigned KICK_W = (KICK_FRAMES > 1) ? $clog2(KICK_FRAMES) : 1;

    logic [KICK_W-1:0] kick_cnt_q, kick_cnt_d;
    logic              kick_done_c;

    assign kick_done_c = (kick_cnt_q == KICK_W'(KICK_FRAMES - 1));

    always_comb begin
        kick_cnt_d = kick_cnt_q;
        if (frame_last) begin
            kick_cnt_d = (state_q == KICK) ? kick_cnt_q + KICK_W'(1) : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            kick_cnt_q <= '0;
        end else begin
            kick_cnt_q <= kick_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transitions are only evaluated on the last cycle of a frame.
    always_comb begin
        state_d = state_q;
        if (frame_last) begin
            case (state_q)
                IDLE: begin
                    if (target_c != '0) begin
`ifdef INTENSITY_PWM_KICKSTART_EN
                        state_d = KICK;
`else
                        state_d = RUN;
`endif
                    end
                end
                RUN: begin
                    if ((level_q == INTENSITY_W'(1)) && (target_c == '0)) begin
                        state_d = IDLE;
                    end
                end
`ifdef INTENSITY_PWM_KICKSTART_EN
                KICK: begin
                    if (target_c == '0) begin
                        state_d = IDLE;
                    end else if (kick_done_c) begin
                        state_d = RUN;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Next level and pwm are computed from next-cycle counters so the registers stay aligned.
    always_comb begin
        level_d = level_q;
        if (frame_last) begin
            if (state_d == RUN) begin
                level_d = (state_q == RUN) ? slew_c : INTENSITY_W'(1);
            end else begin
                level_d = '0;
            end
        end
        pwm_d = ({1'b0, slot_nxt} < level_d);
`ifdef INTENSITY_PWM_KICKSTART_EN
        if (state_d == KICK) begin
            pwm_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            level_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o   = pwm_q;
    assign level_o = level_q;

endmodule : intensity_pwm
